// File: rtl/gb_wavetable_channel_if.sv
// Register-file / mixer side bundle for the wavetable channel.
// The APU register file drives the control inputs and RAM writes (master);
// the channel consumes them and reports level, enable and play position (slave).
interface gb_wavetable_channel_if #(
  parameter int unsigned SAMPLE_W    = 4,
  parameter int unsigned NUM_SAMPLES = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned FREQ_W      = 11
);
  localparam int unsigned POS_W  = $clog2(NUM_SAMPLES);
  localparam int unsigned ADDR_W = $clog2(NUM_SAMPLES / 2);

  logic                  clk_length_ctr;
  logic [LEN_W-1:0]      length;
  logic [1:0]            volume;
  logic                  on;
  logic                  single;
  logic                  start;
  logic [FREQ_W-1:0]     frequency;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [2*SAMPLE_W-1:0] wr_data;
  logic [SAMPLE_W-1:0]   level;
  logic                  enable;
  logic [POS_W-1:0]      sample_pos;

  modport master (
    output clk_length_ctr, length, volume, on, single, start, frequency,
           wr_en, wr_addr, wr_data,
    input  level, enable, sample_pos
  );

  modport slave (
    input  clk_length_ctr, length, volume, on, single, start, frequency,
           wr_en, wr_addr, wr_data,
    output level, enable, sample_pos
  );
endinterface

// File: rtl/gb_wavetable_channel.sv
// Wavetable playback channel: plays NUM_SAMPLES packed samples from an
// internal wave RAM at a programmable rate, with a length counter, DAC
// power gating and 2-bit volume shift. The sample buffer is deliberately
// not refreshed on trigger, so the stale sample plays until the first advance.
module gb_wavetable_channel #(
  parameter int unsigned SAMPLE_W    = 4,
  parameter int unsigned NUM_SAMPLES = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned FREQ_W      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  gb_wavetable_channel_if.slave bus
);
  localparam int unsigned POS_W     = $clog2(NUM_SAMPLES);
  localparam int unsigned ADDR_W    = $clog2(NUM_SAMPLES / 2);
  localparam int unsigned NUM_BYTES = NUM_SAMPLES / 2;

  logic [2*SAMPLE_W-1:0] ram [NUM_BYTES];

  logic [FREQ_W:0]       timer_q;
  logic [POS_W-1:0]      pos_q;
  logic [SAMPLE_W-1:0]   buffer_q;
  logic [LEN_W:0]        len_ctr_q;
  logic                  enable_q;
  logic [SAMPLE_W-1:0]   level_q;

  logic [FREQ_W:0]       period;
  logic [LEN_W:0]        len_load;
  logic [POS_W-1:0]      next_pos;
  logic [2*SAMPLE_W-1:0] next_byte;
  logic [SAMPLE_W-1:0]   next_sample;
  logic                  len_tick;
  logic                  len_expire;
  logic [SAMPLE_W-1:0]   scaled;

  // Reload period and length load value, both one bit wider than their registers
  assign period   = {1'b1, {FREQ_W{1'b0}}} - {1'b0, bus.frequency};
  assign len_load = {1'b1, {LEN_W{1'b0}}} - {1'b0, bus.length};

  // Next play position and the sample it selects (even = upper half of the byte)
  always_comb begin
    next_pos    = pos_q + POS_W'(1);
    next_byte   = ram[next_pos[POS_W-1:1]];
    next_sample = next_pos[0] ? next_byte[SAMPLE_W-1:0]
                              : next_byte[2*SAMPLE_W-1:SAMPLE_W];
  end

  // Length-counter tick qualification and expiry detect
  always_comb begin
    len_tick   = bus.clk_length_ctr && bus.single && enable_q && (len_ctr_q != '0);
    len_expire = len_tick && (len_ctr_q == (LEN_W+1)'(1));
  end

  // Volume shift applied to the sample buffer
  always_comb begin
    scaled = '0;
    case (bus.volume)
      2'b01:   scaled = buffer_q;
      2'b10:   scaled = buffer_q >> 1;
      2'b11:   scaled = buffer_q >> 2;
      default: scaled = '0;
    endcase
  end

  // Wave RAM: writes only land while the channel is idle (pre-trigger enable)
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) ram[i] <= '0;
    end else if (bus.wr_en && !enable_q) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Trigger, frequency timer, play position, length counter and enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q   <= period;
      pos_q     <= '0;
      buffer_q  <= '0;
      len_ctr_q <= '0;
      enable_q  <= 1'b0;
    end else if (bus.start) begin
      // Trigger overrides a coincident timer expiry or length tick.
      timer_q   <= period;
      pos_q     <= '0;
      len_ctr_q <= len_load;
      enable_q  <= bus.on;
    end else begin
      if (enable_q) begin
        if (timer_q == (FREQ_W+1)'(1)) begin
          timer_q  <= period;
          pos_q    <= next_pos;
          buffer_q <= next_sample;
        end else begin
          timer_q <= timer_q - (FREQ_W+1)'(1);
        end
      end
      if (len_tick) len_ctr_q <= len_ctr_q - (LEN_W+1)'(1);
      if (!bus.on || len_expire) enable_q <= 1'b0;
    end
  end

  // Registered mixer output, gated by the channel enable
  always_ff @(posedge clk) begin
    if (!reset) level_q <= '0;
    else        level_q <= enable_q ? scaled : '0;
  end

  assign bus.level      = level_q;
  assign bus.enable     = enable_q;
  assign bus.sample_pos = pos_q;

  logic unused_addr_w;
  assign unused_addr_w = (ADDR_W == 0);
endmodule

// File: tb/tb_gb_wavetable_channel.sv
// Directed bench for gb_wavetable_channel at default parameters,
// frequency 2040 (period 8 clocks).
module tb_gb_wavetable_channel;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  gb_wavetable_channel_if ch_if ();

  gb_wavetable_channel dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ch_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_len(input int n);
    repeat (n) begin
      ch_if.clk_length_ctr = 1'b1;
      tick(1);
      ch_if.clk_length_ctr = 1'b0;
      tick(1);
    end
  endtask

  task automatic trigger();
    ch_if.start = 1'b1;
    tick(1);
    ch_if.start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset                = 1'b0;
    ch_if.clk_length_ctr = 1'b0;
    ch_if.length         = '0;
    ch_if.volume         = 2'b01;
    ch_if.on             = 1'b0;
    ch_if.single         = 1'b0;
    ch_if.start          = 1'b0;
    ch_if.frequency      = 11'd2040;
    ch_if.wr_en          = 1'b0;
    ch_if.wr_addr        = '0;
    ch_if.wr_data        = '0;
    tick(2);
    chk("reset_level", ch_if.level, 0);
    chk("reset_enable", ch_if.enable, 0);
    chk("reset_pos", ch_if.sample_pos, 0);
    reset = 1'b1;

    // Fill wave RAM with 0xF0 while idle
    ch_if.wr_en   = 1'b1;
    ch_if.wr_data = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      ch_if.wr_addr = 4'(i);
      tick(1);
    end
    ch_if.wr_en = 1'b0;

    // Basic playback: T0 trigger, advances at T8k
    ch_if.on = 1'b1;
    trigger();
    chk("trig_enable", ch_if.enable, 1);
    chk("trig_pos", ch_if.sample_pos, 0);
    chk("trig_level_stale", ch_if.level, 0);
    tick(8);
    chk("first_adv_pos", ch_if.sample_pos, 1);
    tick(1);
    chk("lvl_pos1", ch_if.level, 0);
    tick(8);
    chk("lvl_pos2", ch_if.level, 15);
    chk("pos2", ch_if.sample_pos, 2);
    tick(8);
    chk("lvl_pos3", ch_if.level, 0);
    tick(223);
    chk("pos31", ch_if.sample_pos, 31);
    tick(8);
    chk("pos_wrap", ch_if.sample_pos, 0);
    tick(1);
    chk("lvl_wrap", ch_if.level, 15);

    // Volume codes on a buffer of 15
    ch_if.volume = 2'b10;
    tick(1);
    chk("vol10", ch_if.level, 7);
    ch_if.volume = 2'b11;
    tick(1);
    chk("vol11", ch_if.level, 3);
    ch_if.volume = 2'b00;
    tick(1);
    chk("vol00", ch_if.level, 0);
    chk("vol00_enable", ch_if.enable, 1);
    ch_if.volume = 2'b01;

    // Length 200 -> 56 ticks
    ch_if.length = 8'd200;
    ch_if.single = 1'b1;
    trigger();
    pulse_len(55);
    chk("len55_enable", ch_if.enable, 1);
    ch_if.clk_length_ctr = 1'b1;
    tick(1);
    ch_if.clk_length_ctr = 1'b0;
    chk("len56_enable", ch_if.enable, 0);
    tick(1);
    chk("len56_level", ch_if.level, 0);

    // single = 0: counter holds
    ch_if.single = 1'b0;
    trigger();
    pulse_len(300);
    chk("single0_enable", ch_if.enable, 1);

    // Write while enabled is dropped
    ch_if.wr_en   = 1'b1;
    ch_if.wr_addr = 4'd0;
    ch_if.wr_data = 8'h12;
    tick(1);
    ch_if.wr_en = 1'b0;
    trigger();
    tick(9);
    chk("drop_wr_pos", ch_if.sample_pos, 1);
    chk("drop_wr_level", ch_if.level, 0);

    // DAC off, write accepted, retrigger
    ch_if.on = 1'b0;
    tick(1);
    chk("dac_off_enable", ch_if.enable, 0);
    ch_if.wr_en = 1'b1;
    tick(1);
    ch_if.wr_en = 1'b0;
    ch_if.on    = 1'b1;
    tick(1);
    chk("on_no_enable", ch_if.enable, 0);
    trigger();
    tick(1);
    chk("wr_stale_level", ch_if.level, 0);
    tick(8);
    chk("wr_pos1_level", ch_if.level, 2);
    tick(248);
    chk("wr_pos0_level", ch_if.level, 1);

    // Reset mid-operation at pos 5
    trigger();
    tick(40);
    chk("pre_reset_pos", ch_if.sample_pos, 5);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("mid_reset_level", ch_if.level, 0);
    chk("mid_reset_enable", ch_if.enable, 0);
    chk("mid_reset_pos", ch_if.sample_pos, 0);
    trigger();
    tick(9);
    chk("ram_cleared_pos1", ch_if.level, 0);
    tick(8);
    chk("ram_cleared_pos2", ch_if.level, 0);
    chk("ram_cleared_en", ch_if.enable, 1);

    // Trigger with DAC off
    ch_if.on = 1'b0;
    trigger();
    chk("trig_off_enable", ch_if.enable, 0);

    // start + length tick together, length 255 -> counter 1
    ch_if.on             = 1'b1;
    ch_if.single         = 1'b1;
    ch_if.length         = 8'd255;
    ch_if.clk_length_ctr = 1'b1;
    trigger();
    ch_if.clk_length_ctr = 1'b0;
    tick(1);
    chk("start_len_enable", ch_if.enable, 1);
    pulse_len(1);
    chk("start_len_expire", ch_if.enable, 0);

    // Timer expiry coincident with start
    ch_if.single = 1'b0;
    trigger();
    tick(7);
    chk("pre_coinc_pos", ch_if.sample_pos, 0);
    trigger();
    chk("coinc_pos", ch_if.sample_pos, 0);
    tick(7);
    chk("coinc_hold_pos", ch_if.sample_pos, 0);
    tick(1);
    chk("coinc_adv_pos", ch_if.sample_pos, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
